// File: rtl/sdr_arb_pkg.sv
// Shared types for the SDRAM CPU-port arbiter.
//   state_t   : arbiter FSM states
//   grant_t   : grant codes as seen on the grant output
//   sdr_cmd_t : one downstream command (addr/data/be/rw)
// Also holds pending-vector bit positions and a small handshake helper.
package sdr_arb_pkg;

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    ISSUE  = 2'd2,
    WAIT   = 2'd3
  } state_t;

  typedef enum bit [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_SS   = 2'd2,
    GNT_AUX  = 2'd3
  } grant_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic        rw;
  } sdr_cmd_t;

  localparam int BURST_W  = 8;
  localparam int PEND_CPU = 0;
  localparam int PEND_SS  = 1;
  localparam int PEND_AUX = 2;

  localparam sdr_cmd_t CMD_RESET = '{addr: 32'd0, data: 16'd0, be: 2'd0, rw: 1'b1};

  // A toggle requester has work outstanding while its req and ack phases differ.
  function automatic logic is_pending(input logic req, input logic ack);
    return req ^ ack;
  endfunction

endpackage

// File: rtl/sdr_arb_prio.sv
// Combinational winner selection for the SDRAM CPU-port arbiter.
// Order: SS, then AUX once the CPU has used up its burst allowance,
// then CPU, then AUX.
// Ports:
//   pend  in  3        pending vector (PEND_CPU / PEND_SS / PEND_AUX)
//   burst in  BURST_W  consecutive CPU grants taken while AUX waited
//   gnt   out grant_t  selected requester, GNT_NONE when nothing pends
module sdr_arb_prio
  import sdr_arb_pkg::*;
#(
  parameter int CPU_BURST_MAX = 4
) (
  input  logic [2:0]         pend,
  input  logic [BURST_W-1:0] burst,
  output grant_t             gnt
);

  // Fixed priority with an anti-starvation override for AUX.
  always_comb begin
    gnt = GNT_NONE;
    if (pend[PEND_SS]) begin
      gnt = GNT_SS;
    end else if (pend[PEND_AUX] && (burst == BURST_W'(CPU_BURST_MAX))) begin
      gnt = GNT_AUX;
    end else if (pend[PEND_CPU]) begin
      gnt = GNT_CPU;
    end else if (pend[PEND_AUX]) begin
      gnt = GNT_AUX;
    end else begin
      gnt = GNT_NONE;
    end
  end

endmodule

// File: rtl/sdr_cpu_port_arb.sv
// Three-way arbiter sharing the SDRAM CPU port (toggle req/ack, 16-bit)
// between the 68000 bus (cpu_*), the save-state client (ss_*) and an
// auxiliary fetcher (aux_*). One transaction is in flight at a time; the
// winner's command is registered onto sdr_* and its ack toggles one cycle
// after the controller answers.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   {cpu,ss,aux}_addr/data/be/rw/req   requester command + request toggle
//   {cpu,ss,aux}_ack/q         acknowledge toggle + read data
//   sdr_addr/data/be/rw/req    downstream command + request toggle
//   sdr_ack, sdr_q             downstream acknowledge toggle + read data
//   grant                      0 none, 1 cpu, 2 ss, 3 aux
//   timeout                    sticky watchdog flag
// Optional feature: define SDR_CPU_ARB_TIMEOUT_EN to add a WAIT-state
// watchdog that abandons a transaction after TIMEOUT_CYCLES clocks.
module sdr_cpu_port_arb
  import sdr_arb_pkg::*;
#(
  parameter int CPU_BURST_MAX  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [15:0] cpu_data,
  input  logic [1:0]  cpu_be,
  input  logic        cpu_rw,
  input  logic        cpu_req,
  output logic        cpu_ack,
  output logic [15:0] cpu_q,
  input  logic [31:0] ss_addr,
  input  logic [15:0] ss_data,
  input  logic [1:0]  ss_be,
  input  logic        ss_rw,
  input  logic        ss_req,
  output logic        ss_ack,
  output logic [15:0] ss_q,
  input  logic [31:0] aux_addr,
  input  logic [15:0] aux_data,
  input  logic [1:0]  aux_be,
  input  logic        aux_rw,
  input  logic        aux_req,
  output logic        aux_ack,
  output logic [15:0] aux_q,
  output logic [31:0] sdr_addr,
  output logic [15:0] sdr_data,
  output logic [1:0]  sdr_be,
  output logic        sdr_rw,
  output logic        sdr_req,
  input  logic        sdr_ack,
  input  logic [15:0] sdr_q,
  output logic [1:0]  grant,
  output logic        timeout
);

  state_t             state_r, state_nxt_s;
  grant_t             grant_r, winner_s;
  sdr_cmd_t           cmd_r, sel_cmd_s;
  logic               sdr_req_r;
  logic               cpu_ack_r, ss_ack_r, aux_ack_r;
  logic [15:0]        cpu_q_r, ss_q_r, aux_q_r;
  logic [BURST_W-1:0] burst_r;
  logic [2:0]         pend_s;
  logic               sdr_done_s, wd_fire_s;
  logic               latch_s, issue_s, complete_s, adopt_s;
  logic [15:0]        resp_q_s;

  assign pend_s[PEND_CPU] = is_pending(cpu_req, cpu_ack_r);
  assign pend_s[PEND_SS]  = is_pending(ss_req, ss_ack_r);
  assign pend_s[PEND_AUX] = is_pending(aux_req, aux_ack_r);
  assign sdr_done_s       = (sdr_ack == sdr_req_r);
  // An abandoned transaction reports all-ones instead of controller data.
  assign resp_q_s         = wd_fire_s ? 16'hFFFF : sdr_q;

  sdr_arb_prio #(.CPU_BURST_MAX(CPU_BURST_MAX)) u_prio (
    .pend  (pend_s),
    .burst (burst_r),
    .gnt   (winner_s)
  );

`ifdef SDR_CPU_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt_r;
  logic        timeout_r;

  // Watchdog counts WAIT cycles without a controller answer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_r <= 16'd0;
    end else if ((state_r == WAIT) && !sdr_done_s) begin
      wd_cnt_r <= wd_cnt_r + 16'd1;
    end else begin
      wd_cnt_r <= 16'd0;
    end
  end

  assign wd_fire_s = (state_r == WAIT) && !sdr_done_s &&
                     (wd_cnt_r == 16'(TIMEOUT_CYCLES - 1));

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_r <= 1'b0;
    end else if (wd_fire_s) begin
      timeout_r <= 1'b1;
    end else begin
      timeout_r <= timeout_r;
    end
  end

  assign timeout = timeout_r;
`else
  assign wd_fire_s = 1'b0;
  assign timeout   = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RESYNC;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RESYNC:  state_nxt_s = IDLE;
      IDLE:    state_nxt_s = (winner_s != GNT_NONE) ? ISSUE : IDLE;
      ISSUE:   state_nxt_s = WAIT;
      WAIT:    state_nxt_s = (sdr_done_s || wd_fire_s) ? IDLE : WAIT;
      default: state_nxt_s = RESYNC;
    endcase
  end

  // FSM control strobes for the registered datapath.
  always_comb begin
    latch_s    = 1'b0;
    issue_s    = 1'b0;
    complete_s = 1'b0;
    adopt_s    = 1'b0;
    case (state_r)
      RESYNC:  adopt_s    = (sdr_ack != sdr_req_r);
      IDLE:    latch_s    = (winner_s != GNT_NONE);
      ISSUE:   issue_s    = 1'b1;
      WAIT:    complete_s = sdr_done_s || wd_fire_s;
      default: adopt_s    = 1'b0;
    endcase
  end

  // Winner's command source; only the selected requester is ever sampled.
  always_comb begin
    sel_cmd_s = cmd_r;
    case (winner_s)
      GNT_CPU: sel_cmd_s = '{addr: cpu_addr, data: cpu_data, be: cpu_be, rw: cpu_rw};
      GNT_SS:  sel_cmd_s = '{addr: ss_addr,  data: ss_data,  be: ss_be,  rw: ss_rw};
      GNT_AUX: sel_cmd_s = '{addr: aux_addr, data: aux_data, be: aux_be, rw: aux_rw};
      default: sel_cmd_s = cmd_r;
    endcase
  end

  // Downstream command and grant registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_r   <= CMD_RESET;
      grant_r <= GNT_NONE;
    end else if (latch_s) begin
      cmd_r   <= sel_cmd_s;
      grant_r <= winner_s;
    end else if (complete_s) begin
      grant_r <= GNT_NONE;
    end else begin
      grant_r <= grant_r;
    end
  end

  // Downstream request toggle; RESYNC and the watchdog re-align it to sdr_ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdr_req_r <= 1'b0;
    end else if (adopt_s || wd_fire_s) begin
      sdr_req_r <= sdr_ack;
    end else if (issue_s) begin
      sdr_req_r <= ~sdr_req_r;
    end else begin
      sdr_req_r <= sdr_req_r;
    end
  end

  // Completion: return data (captured even for writes) and ack to the winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_ack_r <= 1'b0;
      ss_ack_r  <= 1'b0;
      aux_ack_r <= 1'b0;
      cpu_q_r   <= 16'd0;
      ss_q_r    <= 16'd0;
      aux_q_r   <= 16'd0;
    end else if (complete_s) begin
      case (grant_r)
        GNT_CPU: begin cpu_ack_r <= ~cpu_ack_r; cpu_q_r <= resp_q_s; end
        GNT_SS:  begin ss_ack_r  <= ~ss_ack_r;  ss_q_r  <= resp_q_s; end
        GNT_AUX: begin aux_ack_r <= ~aux_ack_r; aux_q_r <= resp_q_s; end
        default: cpu_ack_r <= cpu_ack_r;
      endcase
    end else begin
      cpu_ack_r <= cpu_ack_r;
    end
  end

  // Burst counter: CPU grants taken while AUX waits; any AUX grant or an
  // idle AUX resets the allowance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_r <= '0;
    end else if (!pend_s[PEND_AUX]) begin
      burst_r <= '0;
    end else if (latch_s && (winner_s == GNT_AUX)) begin
      burst_r <= '0;
    end else if (latch_s && (winner_s == GNT_CPU) && (burst_r < BURST_W'(CPU_BURST_MAX))) begin
      burst_r <= burst_r + BURST_W'(1);
    end else begin
      burst_r <= burst_r;
    end
  end

  assign sdr_addr = cmd_r.addr;
  assign sdr_data = cmd_r.data;
  assign sdr_be   = cmd_r.be;
  assign sdr_rw   = cmd_r.rw;
  assign sdr_req  = sdr_req_r;
  assign grant    = grant_r;
  assign cpu_ack  = cpu_ack_r;
  assign ss_ack   = ss_ack_r;
  assign aux_ack  = aux_ack_r;
  assign cpu_q    = cpu_q_r;
  assign ss_q     = ss_q_r;
  assign aux_q    = aux_q_r;

endmodule

// File: tb/tb_sdr_cpu_port_arb.sv
// Self-checking bench for sdr_cpu_port_arb. A small reference model keeps
// the set of pending requesters and a CPU-streak count, picks winners from
// the priority rules, and plays the SDRAM controller with random latency.
// Optional feature exercised when SDR_CPU_ARB_TIMEOUT_EN is defined.
module tb_sdr_cpu_port_arb;
  import sdr_arb_pkg::*;

  localparam int BURST_MAX = 4;
  localparam int TMO       = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cpu_addr, ss_addr, aux_addr, sdr_addr;
  logic [15:0] cpu_data, ss_data, aux_data, sdr_data;
  logic [1:0]  cpu_be, ss_be, aux_be, sdr_be;
  logic        cpu_rw, ss_rw, aux_rw, sdr_rw;
  logic        cpu_req, ss_req, aux_req, sdr_req;
  logic        cpu_ack, ss_ack, aux_ack, sdr_ack;
  logic [15:0] cpu_q, ss_q, aux_q, sdr_q;
  logic [1:0]  grant;
  logic        timeout;

  int          checks = 0;
  int          errors = 0;
  logic [2:0]  m_pend;
  int          streak;
  logic [15:0] exp_q [3];
  int          order [$];

  sdr_cpu_port_arb #(.CPU_BURST_MAX(BURST_MAX), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_be(cpu_be), .cpu_rw(cpu_rw),
    .cpu_req(cpu_req), .cpu_ack(cpu_ack), .cpu_q(cpu_q),
    .ss_addr(ss_addr), .ss_data(ss_data), .ss_be(ss_be), .ss_rw(ss_rw),
    .ss_req(ss_req), .ss_ack(ss_ack), .ss_q(ss_q),
    .aux_addr(aux_addr), .aux_data(aux_data), .aux_be(aux_be), .aux_rw(aux_rw),
    .aux_req(aux_req), .aux_ack(aux_ack), .aux_q(aux_q),
    .sdr_addr(sdr_addr), .sdr_data(sdr_data), .sdr_be(sdr_be), .sdr_rw(sdr_rw),
    .sdr_req(sdr_req), .sdr_ack(sdr_ack), .sdr_q(sdr_q),
    .grant(grant), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input int i);
    case (i)
      0:       return cpu_ack;
      1:       return ss_ack;
      default: return aux_ack;
    endcase
  endfunction

  function automatic logic req_of(input int i);
    case (i)
      0:       return cpu_req;
      1:       return ss_req;
      default: return aux_req;
    endcase
  endfunction

  function automatic logic [15:0] q_of(input int i);
    case (i)
      0:       return cpu_q;
      1:       return ss_q;
      default: return aux_q;
    endcase
  endfunction

  function automatic sdr_cmd_t cmd_of(input int i);
    sdr_cmd_t c;
    case (i)
      0:       c = '{addr: cpu_addr, data: cpu_data, be: cpu_be, rw: cpu_rw};
      1:       c = '{addr: ss_addr,  data: ss_data,  be: ss_be,  rw: ss_rw};
      default: c = '{addr: aux_addr, data: aux_data, be: aux_be, rw: aux_rw};
    endcase
    return c;
  endfunction

  // Requester i (0 cpu, 1 ss, 2 aux) presents a command and toggles req.
  task automatic post(input int i, input logic [31:0] a, input logic [15:0] d,
                      input logic [1:0] be, input logic rw);
    case (i)
      0:       begin cpu_addr = a; cpu_data = d; cpu_be = be; cpu_rw = rw; cpu_req = ~cpu_req; end
      1:       begin ss_addr  = a; ss_data  = d; ss_be  = be; ss_rw  = rw; ss_req  = ~ss_req;  end
      default: begin aux_addr = a; aux_data = d; aux_be = be; aux_rw = rw; aux_req = ~aux_req; end
    endcase
    m_pend[i] = 1'b1;
  endtask

  // Reference priority: SS, AUX after BURST_MAX CPU wins, CPU, AUX.
  function automatic int pick();
    if (m_pend[1]) return 1;
    if (m_pend[2] && streak >= BURST_MAX) return 2;
    if (m_pend[0]) return 0;
    return 2;
  endfunction

  // Play the controller for the transaction expected from requester i.
  task automatic serve(input int i, input logic [15:0] q, input int dly);
    sdr_cmd_t ec;
    int n;
    ec = cmd_of(i);
    n = 0;
    while (sdr_req === sdr_ack && n < 40) begin tick(); n++; end
    chk("sdr_req_issued", 32'(n < 40), 32'd1);
    chk("grant", 32'(grant), 32'(i + 1));
    chk("sdr_addr", sdr_addr, ec.addr);
    chk("sdr_data", 32'(sdr_data), 32'(ec.data));
    chk("sdr_be", 32'(sdr_be), 32'(ec.be));
    chk("sdr_rw", 32'(sdr_rw), 32'(ec.rw));
    repeat (dly) tick();
    sdr_q = q;
    sdr_ack = ~sdr_ack;
    tick();
    chk("grant_clear", 32'(grant), 32'd0);
    chk("ack_done", 32'(ack_of(i)), 32'(req_of(i)));
    exp_q[i]  = q;
    m_pend[i] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("q_value", 32'(q_of(j)), 32'(exp_q[j]));
      if (m_pend[j]) chk("loser_pending", 32'(ack_of(j) ^ req_of(j)), 32'd1);
    end
  endtask

  // Serve everything pending in model order; CPU re-requests cpu_more times.
  task automatic drain(input int cpu_more);
    int more;
    int w;
    more = cpu_more;
    while (m_pend != 3'b000) begin
      w = pick();
      order.push_back(w + 1);
      serve(w, 16'($urandom), $urandom_range(0, 3));
      if (w == 2 || !m_pend[2]) streak = 0;
      else if (w == 0) streak = (streak < BURST_MAX) ? streak + 1 : BURST_MAX;
      if (w == 0 && more > 0) begin
        more--;
        post(0, $urandom, 16'd0, 2'b11, 1'b1);
      end
    end
  endtask

  initial begin
    logic prev;
    logic nprev;
    int   n;
    int   exp_burst [7];
    cpu_addr = 32'd0; cpu_data = 16'd0; cpu_be = 2'b11; cpu_rw = 1'b1; cpu_req = 1'b0;
    ss_addr  = 32'd0; ss_data  = 16'd0; ss_be  = 2'b11; ss_rw  = 1'b1; ss_req  = 1'b0;
    aux_addr = 32'd0; aux_data = 16'd0; aux_be = 2'b11; aux_rw = 1'b1; aux_req = 1'b0;
    sdr_ack = 1'b0; sdr_q = 16'd0;
    m_pend = 3'b000; streak = 0;
    for (int j = 0; j < 3; j++) exp_q[j] = 16'd0;

    // Reset state
    #1 reset = 1'b1;
    #2;
    chk("rst_sdr_req", 32'(sdr_req), 32'd0);
    chk("rst_sdr_rw", 32'(sdr_rw), 32'd1);
    chk("rst_sdr_addr", sdr_addr, 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_acks", 32'({cpu_ack, ss_ack, aux_ack}), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // CPU read: latency, address hold during WAIT, read data return
    prev = sdr_req;
    nprev = ~prev;
    post(0, 32'h0000_1234, 16'h0000, 2'b11, 1'b1);
    tick();
    chk("lat_n1_req", 32'(sdr_req), 32'(prev));
    chk("lat_n1_grant", 32'(grant), 32'd1);
    tick();
    chk("lat_n2_req", 32'(sdr_req), 32'(nprev));
    chk("rd_addr", sdr_addr, 32'h0000_1234);
    chk("rd_rw", 32'(sdr_rw), 32'd1);
    cpu_addr = 32'hDEAD_0000;
    repeat (3) tick();
    chk("midwait_addr", sdr_addr, 32'h0000_1234);
    sdr_q = 16'hBEEF;
    sdr_ack = ~sdr_ack;
    tick();
    chk("rd_ack", 32'(cpu_ack), 32'(cpu_req));
    chk("rd_q", 32'(cpu_q), 32'h0000_BEEF);
    m_pend[0] = 1'b0;
    exp_q[0] = 16'hBEEF;
    cpu_addr = 32'h0000_1234;

    // Simultaneous CPU read + SS write: SS first
    order.delete();
    post(0, 32'h0000_2000, 16'h0000, 2'b11, 1'b1);
    post(1, 32'h0010_0000, 16'hA5A5, 2'b11, 1'b0);
    drain(0);
    chk("ss_cpu_len", 32'(order.size()), 32'd2);
    if (order.size() == 2) begin
      chk("ss_first", 32'(order[0]), 32'd2);
      chk("cpu_second", 32'(order[1]), 32'd1);
    end

    // AUX pending behind six back-to-back CPU reads
    order.delete();
    exp_burst = '{1, 1, 1, 1, 3, 1, 1};
    post(2, 32'h0040_0000, 16'h0000, 2'b11, 1'b1);
    post(0, 32'h0000_3000, 16'h0000, 2'b11, 1'b1);
    drain(5);
    chk("burst_len", 32'(order.size()), 32'd7);
    for (int k = 0; k < 7 && k < order.size(); k++)
      chk("burst_order", 32'(order[k]), 32'(exp_burst[k]));

    // Random concurrent request sets
    for (int r = 0; r < 25; r++) begin
      int sel;
      sel = $urandom_range(1, 7);
      for (int j = 0; j < 3; j++)
        if (sel[j]) post(j, $urandom, 16'($urandom), 2'($urandom_range(1, 3)), 1'($urandom));
      drain($urandom_range(0, 2));
    end

    // Reset during WAIT with the controller phase at 1
    if (sdr_ack !== 1'b1) begin
      post(0, $urandom, 16'd0, 2'b11, 1'b1);
      drain(0);
    end
    post(0, 32'h0000_5000, 16'd0, 2'b11, 1'b1);
    n = 0;
    while (sdr_req === sdr_ack && n < 40) begin tick(); n++; end
    chk("pre_rst_wait", 32'(grant), 32'd1);
    #2 reset = 1'b1;
    cpu_req = 1'b0; ss_req = 1'b0; aux_req = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_sdr_req", 32'(sdr_req), 32'd0);
    chk("arst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("arst_cpu_q", 32'(cpu_q), 32'd0);
    chk("arst_sdr_rw", 32'(sdr_rw), 32'd1);
    m_pend = 3'b000; streak = 0;
    for (int j = 0; j < 3; j++) exp_q[j] = 16'd0;
    tick();
    reset = 1'b0;
    tick();
    chk("resync_req", 32'(sdr_req), 32'd1);
    chk("resync_grant", 32'(grant), 32'd0);
    post(0, 32'h0000_6000, 16'd0, 2'b11, 1'b1);
    drain(0);
    chk("post_rst_req", 32'(sdr_req), 32'd0);

`ifdef SDR_CPU_ARB_TIMEOUT_EN
    // Controller never answers an AUX read
    post(2, 32'h0080_0000, 16'd0, 2'b11, 1'b1);
    n = 0;
    while (sdr_req === sdr_ack && n < 40) begin tick(); n++; end
    n = 0;
    while (aux_ack !== aux_req && n < 60) begin tick(); n++; end
    chk("tmo_window", 32'(n >= TMO - 1 && n <= TMO + 1), 32'd1);
    chk("tmo_flag", 32'(timeout), 32'd1);
    chk("tmo_q", 32'(aux_q), 32'h0000_FFFF);
    chk("tmo_grant", 32'(grant), 32'd0);
    chk("tmo_realign", 32'(sdr_req), 32'(sdr_ack));
    m_pend[2] = 1'b0;
    exp_q[2] = 16'hFFFF;
    post(0, 32'h0000_7000, 16'd0, 2'b11, 1'b1);
    drain(0);
    chk("tmo_sticky", 32'(timeout), 32'd1);
`else
    chk("timeout_off", 32'(timeout), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdr_cpu_port_arb.md
Name: sdr_cpu_port_arb

Overview:
- Three-way arbiter that shares the single SDRAM CPU port (toggle req/ack, 16-bit) between:
  - the 68000 bus path (ROM/work RAM),
  - the save-state bus client (CPU RAM dump/restore),
  - an auxiliary requester (object/DMA fetch).
- Sits between the top-level chip-select logic and the SDRAM controller.
- Replaces the inline mux, so no requester ever drives the SDRAM port directly.

Parameters:
- CPU_BURST_MAX, 4: consecutive CPU grants allowed while AUX is pending before AUX is forced.
- TIMEOUT_CYCLES, 4096: watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_addr  in  32  CPU byte address; same field set for ss_* and aux_* requesters
- cpu_data  in  16  write data
- cpu_be  in  2  byte enables
- cpu_rw  in  1  1 = read, 0 = write
- cpu_req  in  1  request toggle
- cpu_ack  out  1  acknowledge toggle
- cpu_q  out  16  read data, valid when ack == req
- ss_addr/ss_data/ss_be/ss_rw/ss_req/ss_ack/ss_q: save-state requester, same widths as cpu_*
- aux_addr/aux_data/aux_be/aux_rw/aux_req/aux_ack/aux_q: auxiliary requester, same widths
- sdr_addr  out  32, sdr_data  out  16, sdr_be  out  2, sdr_rw  out  1, sdr_req  out  1: downstream command
- sdr_ack  in  1, sdr_q  in  16: downstream completion
- grant  out  2  0 = none, 1 = cpu, 2 = ss, 3 = aux
- timeout  out  1  sticky watchdog flag (0 when the feature is compiled out)

Behaviour:
- Handshake:
  - Requester x is pending when x_req != x_ack.
  - The requester holds addr/data/be/rw stable from its toggle until ack matches.
  - The arbiter completes a request by toggling x_ack.
- Reset (async) clears:
  - all acks, sdr_req, sdr_addr, sdr_data, sdr_be, grant, timeout, burst counter, and the q outputs to 0;
  - sdr_rw to 1;
  - state goes to RESYNC.
- States: RESYNC, IDLE, ISSUE, WAIT.
- RESYNC (one cycle): if sdr_ack != sdr_req, set sdr_req <= sdr_ack (adopt the controller phase); go to IDLE. No request is granted in RESYNC.
- IDLE: evaluate pending requests in priority order:
  - SS first;
  - then AUX, if the burst counter == CPU_BURST_MAX and AUX is pending;
  - then CPU;
  - then AUX.
  - On a winner: latch its addr/data/be/rw into the sdr_* registers, set grant, go to ISSUE.
- ISSUE: toggle sdr_req; go to WAIT.
  - Net latency: requester toggle at cycle N → sdr_req toggles at N+2 at the earliest.
- WAIT: on sdr_ack == sdr_req:
  - capture sdr_q into the granted x_q, even for writes;
  - toggle x_ack;
  - return grant to 0; go to IDLE.
  - Ack toggles one cycle after the SDRAM ack; the next grant can occur on the following cycle.
- Burst counter:
  - increments on a CPU grant while AUX is pending, saturating at CPU_BURST_MAX;
  - clears on an AUX grant, and whenever AUX is not pending.
- A new toggle from the currently granted requester is not seen until after its ack: single outstanding transaction per requester.
- Simultaneous pending requests: resolved strictly by the priority above within one IDLE cycle. Losers stay pending with no loss.
- Inputs of non-granted requesters are never sampled into sdr_*.
- x_q holds its last value until that requester's next completion.

Optional Feature:
- Macro SDR_CPU_ARB_TIMEOUT_EN.
- When defined:
  - a 16-bit counter runs in WAIT;
  - reaching TIMEOUT_CYCLES sets timeout (sticky until reset), toggles the granted x_ack with x_q = 16'hFFFF, sets sdr_req <= sdr_ack, and returns to IDLE.
- When undefined: the counter is absent, timeout ties to 0, and WAIT waits indefinitely.

Decomposition:
- Package sdr_arb_pkg holds:
  - typedef enum for the states (RESYNC, IDLE, ISSUE, WAIT);
  - typedef enum bit [1:0] for grant codes (GNT_NONE, GNT_CPU, GNT_SS, GNT_AUX);
  - a packed struct sdr_cmd_t {addr, data, be, rw}.
- One sub-module, sdr_arb_prio: combinational priority/anti-starvation pick, taking the pending vector and burst counter and returning the grant code.

Test Plan:
- CPU read, addr 32'h00001234: toggle cpu_req → sdr_req toggles 2 cycles later with sdr_addr = 32'h1234, sdr_rw = 1; respond with sdr_q = 16'hBEEF → cpu_ack toggles next cycle, cpu_q = 16'hBEEF.
- CPU and SS toggle in the same cycle, SS write of 16'hA5A5 to 32'h100000 → SS granted first (grant = 2, sdr_data = 16'hA5A5, sdr_be = 2'b11), then CPU; both acks toggle exactly once.
- AUX pending with 6 back-to-back CPU reads, CPU_BURST_MAX = 4 → grant order CPU×4, AUX, CPU×2.
- Reset asserted in WAIT with sdr_ack = 1 → outputs cleared asynchronously; after release RESYNC sets sdr_req = 1; next CPU request toggles sdr_req to 0 and completes normally.
- With SDR_CPU_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, sdr_ack never answers an aux read → timeout = 1 after 16 cycles, aux_ack toggles, aux_q = 16'hFFFF, arbiter back in IDLE.
- Granted requester changes cpu_addr mid-WAIT → sdr_addr unchanged until completion.
